// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and line-level constants for the framed SIPO receiver.
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial-side and parallel-side signals of the frame controller.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             serial_data_in;
    logic             bit_valid;
    logic             data_ready;
    logic             overrun_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport master (
        output serial_data_in, bit_valid, data_ready, overrun_clr,
        input  data_out, data_valid, frame_err, overrun, busy
    );

    modport slave (
        input  serial_data_in, bit_valid, data_ready, overrun_clr,
        output data_out, data_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/sipo_frame_ctrl_shift.sv
// Serial-in/parallel-out register that advances only when shift_en is high.
module sipo_shift_en #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             serial_data_in,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    // MSB-first shifts toward the top so the first bit ends up in q[WIDTH-1].
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (MSB_FIRST) begin : g_left
            if (gi == 0) begin : g_in
                assign w_q_next[gi] = serial_data_in;
            end else begin : g_mid
                assign w_q_next[gi] = r_q[gi-1];
            end
        end else begin : g_right
            if (gi == WIDTH-1) begin : g_in
                assign w_q_next[gi] = serial_data_in;
            end else begin : g_mid
                assign w_q_next[gi] = r_q[gi+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Start/data/stop framing FSM around the SIPO, with a valid/ready word output
// and sticky overrun when a good word arrives before the previous one is taken.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             rst,
    sipo_frame_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             w_shift_en;
    logic             w_good;
    logic             w_bad;
    logic [WIDTH-1:0] w_shift_q;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_busy;

    sipo_shift_en #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk            (clk),
        .rst            (rst),
        .shift_en       (w_shift_en),
        .serial_data_in (bus.serial_data_in),
        .q              (w_shift_q)
    );

    assign w_shift_en = bus.bit_valid && (r_state == DATA);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.bit_valid && bus.serial_data_in == START_BIT) begin
                    w_state_next = DATA;
                    w_cnt_next   = '0;
                end
            end
            DATA: begin
                if (bus.bit_valid) begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                // A bad stop returns to IDLE; it is never reused as a start bit.
                if (bus.bit_valid) begin
                    w_state_next = IDLE;
                    if (bus.serial_data_in == STOP_BIT) begin
                        w_good = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    // Commit wins over the handshake clear so a back-to-back word is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            if (w_good && (!r_data_valid || bus.data_ready)) begin
                r_data_out   <= w_shift_q;
                r_data_valid <= 1'b1;
            end else if (r_data_valid && bus.data_ready) begin
                r_data_valid <= 1'b0;
            end
            if (w_good && r_data_valid && !bus.data_ready) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench: one MSB-first and one LSB-first instance share the same stimulus.
module tb_sipo_frame_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_busy, n_valid, n_ferr;

    always #5 clk = ~clk;

    sipo_frame_ctrl_if #(.WIDTH(4)) ifa ();
    sipo_frame_ctrl_if #(.WIDTH(4)) ifb ();

    assign ifb.serial_data_in = ifa.serial_data_in;
    assign ifb.bit_valid      = ifa.bit_valid;
    assign ifb.data_ready     = ifa.data_ready;
    assign ifb.overrun_clr    = ifa.overrun_clr;

    sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic tick();
        @(posedge clk);
        #1;
        n_busy  += int'(ifa.busy);
        n_valid += int'(ifa.data_valid);
        n_ferr  += int'(ifa.frame_err);
    endtask

    task automatic clear_counts();
        n_busy = 0; n_valid = 0; n_ferr = 0;
    endtask

    // Sends nbits bits starting at bits[5]; gapmax>0 inserts 1..gapmax idle cycles after each bit.
    task automatic send_bits(input logic [5:0] bits, input int nbits, input int gapmax);
        for (int i = 0; i < nbits; i++) begin
            ifa.serial_data_in = bits[5-i];
            ifa.bit_valid      = 1'b1;
            tick();
            if (gapmax > 0 && i != nbits - 1) begin
                ifa.bit_valid = 1'b0;
                repeat ($urandom_range(1, gapmax)) tick();
            end
        end
        ifa.bit_valid      = 1'b0;
        ifa.serial_data_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ifa.serial_data_in = 1'($urandom_range(0, 1));
            ifa.bit_valid      = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (ifa.data_out !== 4'b0000 || ifa.data_valid !== 1'b0 || ifa.frame_err !== 1'b0 ||
                ifa.overrun !== 1'b0 || ifa.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got out=%b v=%b fe=%b ov=%b busy=%b expected all 0",
                         c, ifa.data_out, ifa.data_valid, ifa.frame_err, ifa.overrun, ifa.busy);
            end
        end
        ifa.bit_valid = 1'b0;
        ifa.serial_data_in = 1'b0;
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        ifa.data_ready = 1'b1;
        clear_counts();
        send_bits(6'b110110, 6, 0);
        checks++;
        if (ifa.data_out !== 4'b1011 || ifa.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_word got %b v=%b expected 1011 v=1", ifa.data_out, ifa.data_valid);
        end
        checks++;
        if (ifb.data_out !== 4'b1101) begin
            errors++;
            $display("FAIL basic_word_lsb got %b expected 1101", ifb.data_out);
        end
        checks++;
        if (n_busy != 5) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d expected 5", n_busy);
        end
        tick();
        checks++;
        if (ifa.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_drop got %b expected 0", ifa.data_valid);
        end
        checks++;
        if (n_valid != 1 || n_ferr != 0) begin
            errors++;
            $display("FAIL basic_pulses got valid=%0d ferr=%0d expected 1 and 0", n_valid, n_ferr);
        end
        $display("test_basic done");
    endtask

    task automatic test_gaps();
        clear_counts();
        send_bits(6'b110110, 6, 3);
        repeat (3) tick();
        checks++;
        if (ifa.data_out !== 4'b1011) begin
            errors++;
            $display("FAIL gaps_word got %b expected 1011", ifa.data_out);
        end
        checks++;
        if (n_valid != 1 || n_ferr != 0) begin
            errors++;
            $display("FAIL gaps_pulses got valid=%0d ferr=%0d expected 1 and 0", n_valid, n_ferr);
        end
        $display("test_gaps done");
    endtask

    task automatic test_frame_err();
        clear_counts();
        send_bits(6'b101011, 6, 0);
        checks++;
        if (ifa.frame_err !== 1'b1 || ifa.data_valid !== 1'b0 || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_pulse got fe=%b v=%b busy=%b expected 1 0 0",
                     ifa.frame_err, ifa.data_valid, ifa.busy);
        end
        tick();
        checks++;
        if (ifa.frame_err !== 1'b0 || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_one_cycle got fe=%b busy=%b expected 0 0", ifa.frame_err, ifa.busy);
        end
        send_bits(6'b100110, 6, 0);
        checks++;
        if (ifa.data_out !== 4'b0011 || ifa.data_valid !== 1'b1 || ifb.data_out !== 4'b1100) begin
            errors++;
            $display("FAIL ferr_recover got a=%b v=%b b=%b expected 0011 1 1100",
                     ifa.data_out, ifa.data_valid, ifb.data_out);
        end
        tick();
        $display("test_frame_err done");
    endtask

    task automatic test_overrun();
        ifa.data_ready = 1'b0;
        send_bits(6'b110110, 6, 0);
        checks++;
        if (ifa.data_out !== 4'b1011 || ifa.data_valid !== 1'b1 || ifa.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first got %b v=%b ov=%b expected 1011 1 0",
                     ifa.data_out, ifa.data_valid, ifa.overrun);
        end
        send_bits(6'b101100, 6, 0);
        checks++;
        if (ifa.data_out !== 4'b1011 || ifa.data_valid !== 1'b1 || ifa.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop got %b v=%b ov=%b expected 1011 1 1",
                     ifa.data_out, ifa.data_valid, ifa.overrun);
        end
        ifa.overrun_clr = 1'b1;
        tick();
        ifa.overrun_clr = 1'b0;
        checks++;
        if (ifa.overrun !== 1'b0 || ifa.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear got ov=%b v=%b expected 0 1", ifa.overrun, ifa.data_valid);
        end
        ifa.data_ready = 1'b1;
        tick();
        checks++;
        if (ifa.data_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_accept got v=%b expected 0", ifa.data_valid);
        end
        $display("test_overrun done");
    endtask

    task automatic test_mid_reset();
        send_bits(6'b110000, 3, 0);
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before got %b expected 1", ifa.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ifa.busy !== 1'b0 || ifa.data_out !== 4'b0000 ||
            u_dut_a.w_shift_q !== 4'b0000 || u_dut_b.w_shift_q !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_clear got busy=%b out=%b qa=%b qb=%b expected 0 0000 0000 0000",
                     ifa.busy, ifa.data_out, u_dut_a.w_shift_q, u_dut_b.w_shift_q);
        end
        send_bits(6'b101010, 6, 0);
        checks++;
        if (ifa.data_out !== 4'b0101 || ifa.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_msb got %b v=%b expected 0101 1", ifa.data_out, ifa.data_valid);
        end
        checks++;
        if (ifb.data_out !== 4'b1010 || ifb.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_lsb got %b v=%b expected 1010 1", ifb.data_out, ifb.data_valid);
        end
        tick();
        $display("test_mid_reset done");
    endtask

    initial begin
        ifa.serial_data_in = 1'b0;
        ifa.bit_valid      = 1'b0;
        ifa.data_ready     = 1'b0;
        ifa.overrun_clr    = 1'b0;
        clear_counts();
        test_reset();
        test_basic();
        test_gaps();
        test_frame_err();
        test_overrun();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Frame-level controller that sequences a serial-in/parallel-out shift register.
- Detects a start bit on a qualified serial stream and shifts exactly WIDTH data bits into an internal SIPO, then checks the stop bit.
- Good words are presented on a valid/ready parallel output.
- Sits between a serial bit source, which strobes bit_valid at arbitrary gaps, and a parallel word consumer.

Parameters:
WIDTH, 4, data bits per frame (>=2)
MSB_FIRST, 1, 1: first data bit lands in data_out[WIDTH-1]; 0: first data bit lands in data_out[0]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
serial_data_in  input  1  serial bit, sampled only when bit_valid=1
bit_valid  input  1  qualifies serial_data_in for one clk
data_ready  input  1  consumer accepts data_out when data_valid=1
overrun_clr  input  1  clears sticky overrun
data_out  output  WIDTH  last good received word
data_valid  output  1  data_out holds an unconsumed word
frame_err  output  1  one-cycle pulse on bad stop bit
overrun  output  1  sticky; good word dropped because the previous word was unconsumed
busy  output  1  high while state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, bit counter=0, shift register=0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - rst overrides all other inputs, including mid-frame; a partial frame is discarded.
- Line convention: idle/stop level=0, start bit=1.
- FSM states:
  - IDLE:
    - bit_valid && serial_data_in==1 -> DATA; counter cleared.
    - bit_valid && serial_data_in==0 -> ignored (idle line).
  - DATA:
    - Each bit_valid shifts serial_data_in into the SIPO and increments the counter.
    - The bit_valid that makes the counter reach WIDTH -> STOP.
  - STOP:
    - On bit_valid, serial_data_in==0 -> good frame, commit (below), -> IDLE.
    - On bit_valid, serial_data_in==1 -> frame_err=1 for exactly the next cycle, word discarded, -> IDLE. A 1 is not re-interpreted as a new start bit.
- bit_valid=0 in any state: state, counter and shift register hold.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
- Counter width is $clog2(WIDTH+1); the counter never wraps within a frame.
- Commit on good stop, decided at the same edge:
  - data_valid==0, or data_ready==1 (old word accepted this edge): data_out <= shift reg, data_valid <= 1.
  - data_valid==1 && data_ready==0: data_out unchanged, new word dropped, overrun <= 1.
- Latency: data_valid rises at the clk edge that samples the stop bit. Minimum frame is WIDTH+2 bit_valid strobes; back-to-back frames are supported.
- Handshake:
  - data_valid && data_ready at an edge clears data_valid unless a commit occurs on the same edge; in that case data_valid stays 1 with the new word.
  - data_out is stable while data_valid=1 && data_ready=0.
- overrun clears on overrun_clr=1. If a set and a clear occur on the same edge, the set wins.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Package sipo_ctrl_pkg:
  - state enum {IDLE, DATA, STOP}
  - START_BIT=1'b1, STOP_BIT=1'b0
- Sub-module sipo_shift_en:
  - Parameters WIDTH, MSB_FIRST.
  - Ports clk, rst, shift_en, serial_data_in, q[WIDTH-1:0].
  - Synchronous active-high reset to 0; shifts only when shift_en=1.
- The controller holds the FSM, counter, output register and flags.

Test Plan:
1. rst=1 for 3 cycles with random serial_data_in/bit_valid -> data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0 throughout.
2. WIDTH=4, MSB_FIRST=1, bit_valid=1 continuous, data_ready=1, serial sequence 1,1,0,1,1,0 -> data_out=4'b1011, data_valid high exactly 1 cycle after the stop edge, busy high for 5 cycles.
3. Same frame with bit_valid=1 strobes separated by random 1-3 idle cycles -> data_out=4'b1011, single data_valid pulse, no frame_err.
4. Frame 1,0,1,0,1 then stop=1 -> frame_err 1-cycle pulse, data_valid stays 0, FSM returns to IDLE; next frame 1,0,0,1,1,0 -> data_out=4'b0011.
5. data_ready=0; frames carrying 1011 then 0110 -> data_out stays 4'b1011, data_valid=1, overrun=1. Pulse overrun_clr -> overrun=0. Raise data_ready -> data_valid drops the next cycle.
6. rst pulsed after start plus 2 data bits -> busy=0, shift register cleared; following frame 1,0,1,0,1,0 -> data_out=4'b0101. Repeat with MSB_FIRST=0 -> data_out=4'b1010.
